// File: rtl/mips_pc_sequencer.sv
// Program-counter sequencer for the Harvard MIPS core: sequential fetch, branch/jump
// redirects with an optional delay slot, stalls, and halt on a jump to HALT_ADDR.
module mips_pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter int          DELAY_SLOT   = 1,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        j_valid,
    input  logic [25:0] j_index,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    output logic [31:0] instr_address,
    output logic [31:0] link_addr,
    output logic        active,
    output logic        fault,
    output logic        dslot_err
);
    localparam logic [1:0] S_SEQ  = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc, tgt_q;
    logic [31:0] pc_plus4, br_tgt, j_tgt, tgt;
    logic        adv, redirect, misaligned;

    assign active   = (state != S_HALT);
    assign adv      = clk_enable & ~stall & active & ~reset;
    assign redirect = jr_valid | j_valid | br_taken;

    assign pc_plus4 = pc + 32'd4;
    assign br_tgt   = pc_plus4 + {{14{br_offset[15]}}, br_offset, 2'b00};
    assign j_tgt    = {pc_plus4[31:28], j_index, 2'b00};

    always_comb begin
        tgt = br_tgt;
        if (jr_valid)     tgt = jr_target;
        else if (j_valid) tgt = j_tgt;
    end

    assign misaligned    = (tgt[1:0] != 2'b00);
    assign instr_address = pc;
    assign link_addr     = pc + ((DELAY_SLOT != 0) ? 32'd8 : 32'd4);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_VECTOR;
            tgt_q     <= 32'd0;
            state     <= S_SEQ;
            fault     <= 1'b0;
            dslot_err <= 1'b0;
        end else if (adv) begin
            case (state)
                S_SEQ: begin
                    if (!redirect) begin
                        pc <= pc_plus4;
                    end else if (misaligned) begin
                        // pc stays on the faulting jump; no delay slot runs
                        fault <= 1'b1;
                        state <= S_HALT;
                    end else if (DELAY_SLOT != 0) begin
                        pc    <= pc_plus4;
                        tgt_q <= tgt;
                        state <= S_PEND;
                    end else if (tgt == HALT_ADDR) begin
                        state <= S_HALT;
                    end else begin
                        pc <= tgt;
                    end
                end
                S_PEND: begin
                    // a redirect from the delay slot is dropped, only flagged
                    if (redirect) dslot_err <= 1'b1;
                    if (tgt_q == HALT_ADDR) begin
                        state <= S_HALT;
                    end else begin
                        pc    <= tgt_q;
                        state <= S_SEQ;
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Randomized + directed bench for mips_pc_sequencer; two instances (delay slot on/off)
// are tracked by an abstract per-instruction model.
module tb_mips_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset, clk_enable, stall, br_taken, j_valid, jr_valid;
    logic [15:0] br_offset;
    logic [25:0] j_index;
    logic [31:0] jr_target;

    logic [31:0] ia1, la1, ia0, la0;
    logic        act1, flt1, derr1, act0, flt0, derr0;

    int n_chk  = 0;
    int n_fail = 0;

    // model state: index 0 = delay slot enabled, index 1 = no delay slot
    logic [31:0] m_pc   [2];
    logic [31:0] m_ptgt [2];
    bit          m_pend [2];
    bit          m_halt [2];
    bit          m_fault[2];
    bit          m_derr [2];

    always #5 clk = ~clk;

    mips_pc_sequencer #(.DELAY_SLOT(1)) dut_ds1 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .stall(stall),
        .br_taken(br_taken), .br_offset(br_offset), .j_valid(j_valid), .j_index(j_index),
        .jr_valid(jr_valid), .jr_target(jr_target), .instr_address(ia1), .link_addr(la1),
        .active(act1), .fault(flt1), .dslot_err(derr1));

    mips_pc_sequencer #(.DELAY_SLOT(0)) dut_ds0 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .stall(stall),
        .br_taken(br_taken), .br_offset(br_offset), .j_valid(j_valid), .j_index(j_index),
        .jr_valid(jr_valid), .jr_target(jr_target), .instr_address(ia0), .link_addr(la0),
        .active(act0), .fault(flt0), .dslot_err(derr0));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_target(input logic [31:0] pc);
        logic [31:0] nxt;
        int          off;
        nxt = pc + 32'd4;
        if (jr_valid) return jr_target;
        if (j_valid)  return {nxt[31:28], j_index, 2'b00};
        off = int'($signed(br_offset)) * 4;
        return nxt + 32'(off);
    endfunction

    task automatic model_step();
        logic [31:0] t;
        bit          req;
        for (int i = 0; i < 2; i++) begin
            req = jr_valid | j_valid | br_taken;
            if (reset) begin
                m_pc[i] = 32'hBFC00000; m_pend[i] = 0; m_halt[i] = 0;
                m_fault[i] = 0; m_derr[i] = 0;
            end else if (clk_enable && !stall && !m_halt[i]) begin
                t = model_target(m_pc[i]);
                if (m_pend[i]) begin
                    if (req) m_derr[i] = 1;
                    m_pend[i] = 0;
                    if (m_ptgt[i] == 32'h0) m_halt[i] = 1;
                    else m_pc[i] = m_ptgt[i];
                end else if (!req) begin
                    m_pc[i] = m_pc[i] + 32'd4;
                end else if (t % 4 != 0) begin
                    m_fault[i] = 1; m_halt[i] = 1;
                end else if (i == 0) begin
                    m_pc[i] = m_pc[i] + 32'd4; m_pend[i] = 1; m_ptgt[i] = t;
                end else if (t == 32'h0) begin
                    m_halt[i] = 1;
                end else begin
                    m_pc[i] = t;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("ds1_pc",   ia1,   m_pc[0]);
        chk("ds1_link", la1,   m_pc[0] + 32'd8);
        chk("ds1_act",  32'(act1),  32'(!m_halt[0]));
        chk("ds1_flt",  32'(flt1),  32'(m_fault[0]));
        chk("ds1_derr", 32'(derr1), 32'(m_derr[0]));
        chk("ds0_pc",   ia0,   m_pc[1]);
        chk("ds0_link", la0,   m_pc[1] + 32'd4);
        chk("ds0_act",  32'(act0),  32'(!m_halt[1]));
        chk("ds0_flt",  32'(flt0),  32'(m_fault[1]));
        chk("ds0_derr", 32'(derr0), 32'(m_derr[1]));
    endtask

    task automatic idle();
        reset = 0; clk_enable = 1; stall = 0;
        br_taken = 0; j_valid = 0; jr_valid = 0;
        br_offset = '0; j_index = '0; jr_target = '0;
    endtask

    // one clock: model follows the sampled inputs, outputs checked mid-cycle
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        idle();
    endtask

    task automatic do_reset();
        idle(); reset = 1; tick();
    endtask

    task automatic do_jr(input logic [31:0] t);
        jr_valid = 1; jr_target = t; tick();
    endtask

    initial begin
        idle();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 'x; m_ptgt[i] = '0; m_pend[i] = 0; m_halt[i] = 0; m_fault[i] = 0; m_derr[i] = 0;
        end
        @(negedge clk);

        // reset and free-run
        do_reset();
        chk("t1_reset_pc", ia1, 32'hBFC00000);
        chk("t1_active", 32'(act1), 32'd1);
        chk("t1_fault", 32'(flt1), 32'd0);
        tick(); chk("t1_pc1", ia1, 32'hBFC00004);
        // jr with delay slot
        chk("t2_link", la1, 32'hBFC0000C);
        do_jr(32'hC0000000); chk("t2_slot", ia1, 32'hBFC00008);
        tick();              chk("t2_tgt", ia1, 32'hC0000000);
        repeat (4) tick();   chk("t3_pc", ia1, 32'hC0000010);
        br_taken = 1; br_offset = 16'hFFFF; tick(); chk("t3_br_slot", ia1, 32'hC0000014);
        tick();                                     chk("t3_br_tgt", ia1, 32'hC0000010);
        j_valid = 1; j_index = 26'h0000040; tick(); chk("t3_j_slot", ia1, 32'hC0000014);
        tick();                                     chk("t3_j_tgt", ia1, 32'hC0000100);

        // halt on jump to zero
        do_jr(32'hC0000000); tick(); chk("t4_pc", ia1, 32'hC0000000);
        do_jr(32'h0); chk("t4_slot", ia1, 32'hC0000004); chk("t4_slot_act", 32'(act1), 32'd1);
        tick(); chk("t4_act", 32'(act1), 32'd0);
        jr_valid = 1; jr_target = 32'h40; tick();
        repeat (4) tick(); chk("t4_frozen", ia1, 32'hC0000004);

        // misaligned target
        do_reset(); tick();
        do_jr(32'hC0000002);
        chk("t5_fault", 32'(flt1), 32'd1); chk("t5_act", 32'(act1), 32'd0);
        chk("t5_pc", ia1, 32'hBFC00004);
        // redirect inside delay slot
        do_reset(); tick();
        do_jr(32'hC0000000);
        br_taken = 1; br_offset = 16'h0100; tick();
        chk("t5_derr", 32'(derr1), 32'd1); chk("t5_derr_pc", ia1, 32'hC0000000);
        do_reset(); chk("t6_rst_derr", 32'(derr1), 32'd0);

        // stall and clock-enable during PEND
        tick(); do_jr(32'hC0000000);
        repeat (3) begin stall = 1; tick(); end
        chk("t6_stall", ia1, 32'hBFC00008);
        repeat (2) begin clk_enable = 0; tick(); end
        chk("t6_ce", ia1, 32'hBFC00008);
        tick(); chk("t6_tgt", ia1, 32'hC0000000);
        // reset mid-PEND discards the target
        do_jr(32'hC0000040);
        do_reset(); chk("t6_rst_pc", ia1, 32'hBFC00000);
        tick(); chk("t6_rst_seq", ia1, 32'hBFC00004);
        tick(); chk("t6_rst_seq2", ia1, 32'hBFC00008);

        // sequential wrap past the top of memory
        do_jr(32'hFFFFFFF8); tick(); chk("wrap_a", ia1, 32'hFFFFFFF8);
        tick(); chk("wrap_link", la1, 32'h00000004);
        tick(); chk("wrap_pc", ia1, 32'h00000000); chk("wrap_act", 32'(act1), 32'd1);

        // random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ((m_halt[0] && m_halt[1]) ? ($urandom_range(3) == 0) : ($urandom_range(127) == 0))
                reset = 1;
            clk_enable = ($urandom_range(9) != 0);
            stall      = ($urandom_range(7) == 0);
            br_taken   = ($urandom_range(7) == 0);
            j_valid    = ($urandom_range(11) == 0);
            jr_valid   = ($urandom_range(11) == 0);
            br_offset  = 16'($urandom);
            j_index    = 26'($urandom);
            case ($urandom_range(9))
                0:       jr_target = 32'h0;
                1:       jr_target = $urandom | 32'h1;
                default: jr_target = $urandom & 32'hFFFFFFFC;
            endcase
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_pc_sequencer.md
# mips_pc_sequencer

Program-counter and control-transfer sequencer for the Harvard MIPS CPU core. Owns `instr_address`. It handles sequential fetch, conditional branches, `j`/`jal`, `jr`/`jalr`, a configurable branch-delay slot, stalls, and halt-on-jump-to-zero, which drives `active` low. It sits between the decode/execute stage, which supplies resolved redirects, and the instruction-memory port.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'hBFC00000: value loaded into `instr_address` on reset.
- `DELAY_SLOT`, default 1: 1 executes one delay-slot instruction after a redirect; 0 redirects immediately.
- `HALT_ADDR`, default 32'h00000000: a jump target equal to this value halts the CPU.

Ports:
- `clk` in, 1: the single clock.
- `reset` in, 1: synchronous, active-high.
- `clk_enable` in, 1: global advance enable; low freezes all state.
- `stall` in, 1: local hold, e.g. a multi-cycle divide; high freezes all state.
- `br_taken` in, 1: the current instruction is a taken conditional branch.
- `br_offset` in, 16: raw branch immediate.
- `j_valid` in, 1: the current instruction is `j` or `jal`.
- `j_index` in, 26: jump index field.
- `jr_valid` in, 1: the current instruction is `jr` or `jalr`.
- `jr_target` in, 32: register value for `jr`/`jalr`.
- `instr_address` out, 32: fetch address of the current instruction.
- `link_addr` out, 32: combinational return address for `jal`/`jalr`/`bgezal`/`bltzal`.
- `active` out, 1: high while the CPU runs.
- `fault` out, 1: sticky; set on a misaligned target.
- `dslot_err` out, 1: sticky; set when a redirect is requested inside a delay slot.

## Operation
The block advances only when `adv = clk_enable & ~stall & active & ~reset`. When `adv` is low, every register holds its value.

States:
- SEQ: normal sequential fetch.
- PEND: target latched; the delay slot is executing. Reachable only when DELAY_SLOT = 1.
- HALT: terminal until reset.

Redirect priority when several requests are asserted together: `jr_valid` > `j_valid` > `br_taken`. No error is flagged for multiple requests.

Target computation, with `pc = instr_address` and all arithmetic modulo 2^32:
- Branch: `pc + 4 + (sext(br_offset) << 2)`.
- Jump: `{(pc+4)[31:28], j_index, 2'b00}`.
- Register jump: `jr_target`.

SEQ transitions on `adv`:
- No redirect: `pc <= pc+4`.
- Redirect with DELAY_SLOT = 1: `pc <= pc+4`, latch the target, go to PEND.
- Redirect with DELAY_SLOT = 0:
  - Target equals HALT_ADDR: go to HALT. `pc` holds.
  - Otherwise: `pc <= target`.

PEND transitions on `adv`:
- Latched target equals HALT_ADDR: go to HALT. `pc` holds.
- Otherwise: `pc <= target`, go to SEQ.
- Any redirect request in this cycle is ignored and sets `dslot_err`.

HALT:
- `active = 0`, `pc` frozen.
- All inputs ignored.
- Only `reset` exits this state.

Misaligned target (`target[1:0] != 0`) when the target is latched or applied:
- Set `fault`.
- Go to HALT immediately, with no delay slot executed.
- `pc` holds the address of the faulting jump.

`link_addr`:
- `instr_address + 8` when DELAY_SLOT = 1.
- `instr_address + 4` when DELAY_SLOT = 0.
- Wraps modulo 2^32.

## Timing
- Reset values, applied on the posedge where `reset` = 1 and held while it stays high:
  - `instr_address = RESET_VECTOR`, state SEQ.
  - `active = 1`, `fault = 0`, `dslot_err = 0`.
- Reset mid-PEND discards the latched target.
- Redirect inputs are sampled on the posedge and qualified by `adv`. `instr_address` updates one cycle later.
- Redirect latency in cycles from the jump's cycle:
  - DELAY_SLOT = 1: the delay slot appears at +1 and the target at +2.
  - DELAY_SLOT = 0: the target appears at +1.
- Halt latency: `active` falls at the same posedge at which the target would have been applied.
  - DELAY_SLOT = 1: cycle +2.
  - DELAY_SLOT = 0: cycle +1.
- A stall during PEND stretches the delay slot. The target is still applied on the first subsequent `adv` edge.
- `pc+4` from 32'hFFFFFFFC wraps to 32'h00000000. This wrap is sequential and does not halt.

## Test plan
1. Reset, then 3 free-running cycles -> `instr_address` = BFC00000, BFC00004, BFC00008, BFC0000C; `active` = 1; `fault` = 0.
2. `jr_valid` with `jr_target` = C0000000 at pc BFC00004 (DELAY_SLOT = 1) -> next addresses BFC00008, then C0000000; `link_addr` at the jr cycle = BFC0000C.
3. `br_taken` with `br_offset` = 16'hFFFF at pc C0000010 -> addresses C0000014, then C0000010. Then `j_valid` with `j_index` = 26'h0000040 at pc C0000010 -> addresses C0000014, then C0000100.
4. `jr_target` = 0 at pc C0000000 -> delay slot C0000004 executes; `active` drops at the next edge; `instr_address` remains C0000004 for 5 further cycles.
5. `jr_target` = C0000002 -> `fault` = 1 and `active` = 0 the next cycle; `pc` stays at the jr address. Separately, `br_taken` during PEND -> `dslot_err` = 1 and the original target is still applied.
6. `stall` = 1 for 3 cycles during PEND, then `clk_enable` = 0 for 2 cycles -> `instr_address` frozen throughout; target applied on the first advancing edge. Reset asserted mid-PEND -> BFC00000, SEQ, all flags cleared.
